// File: rtl/gtoex_pipe.sv
// -----------------------------------------------------------------------------
// gtoex_pipe
//   Converts 4-bit Gray-code digits to excess-3 and buffers the results in a
//   small FIFO. Each digit is converted when it is accepted. Binary values
//   0..9 are stored as {0, b+3}. Values 10..15 are stored as {1, 4'b0000}.
//
//   Handshake: a transfer happens on any rising edge where valid and ready
//   are both high. in_ready depends only on registered occupancy, and
//   out_valid/out_ex/out_error come only from registered state. This means
//   there is no combinational path from in_* to out_*, and a pop from a full
//   FIFO frees a slot only on the following cycle.
//
//   Optional feature: define GTOEX_ERR_CNT_EN to add the err_cnt port. This
//   is a saturating count of accepted digits that were not valid decimal
//   values.
//
// Parameters
//   DEPTH      FIFO entries; power of two, >= 2 (default 4)
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears pointers, level, data)
//   in_valid   producer has a Gray digit on in_g
//   in_ready   FIFO not full
//   in_g       4-bit Gray digit
//   out_valid  FIFO not empty; out_ex/out_error show the head entry
//   out_ready  consumer takes the head entry
//   out_ex     excess-3 digit of the head entry
//   out_error  head entry was not a decimal value
//   err_cnt    saturating error count (only with GTOEX_ERR_CNT_EN)
//   level      current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module gtoex_pipe #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_g,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_ex,
  output logic                     out_error,
`ifdef GTOEX_ERR_CNT_EN
  output logic [7:0]               err_cnt,
`endif
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [4:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  logic          in_fire, out_fire;
  logic [3:0]    bin;
  logic          bad_digit;
  logic [4:0]    entry;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin[3]    = in_g[3];
    bin[2]    = bin[3] ^ in_g[2];
    bin[1]    = bin[2] ^ in_g[1];
    bin[0]    = bin[1] ^ in_g[0];
    bad_digit = (bin > 4'd9);
    entry     = bad_digit ? 5'b1_0000 : {1'b0, 4'(bin + 4'd3)};
  end

  assign in_ready  = (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign in_fire   = in_valid  && in_ready;
  assign out_fire  = out_valid && out_ready;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (in_fire)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (out_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({in_fire, out_fire})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // The storage is cleared on reset so the head reads as zero until the first write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (in_fire) mem_q[wr_ptr_q] <= entry;
    end
  end

  assign out_error = mem_q[rd_ptr_q][4];
  assign out_ex    = mem_q[rd_ptr_q][3:0];
  assign level     = level_q;

`ifdef GTOEX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (in_fire && bad_digit && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_gtoex_pipe.sv
module tb_gtoex_pipe;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_g;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_ex;
  logic          out_error;
  logic [LW-1:0] level;
`ifdef GTOEX_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  gtoex_pipe #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_g      (in_g),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ex    (out_ex),
    .out_error (out_error),
`ifdef GTOEX_ERR_CNT_EN
    .err_cnt   (err_cnt),
`endif
    .level     (level)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  // Hand-computed vectors: Gray input and expected {error, ex}.
  logic [3:0] tg [14];
  logic [4:0] te [14];
  initial begin
    tg[0]  = 4'b0000; te[0]  = 5'b0_0011; // b=0
    tg[1]  = 4'b0001; te[1]  = 5'b0_0100; // b=1
    tg[2]  = 4'b0011; te[2]  = 5'b0_0101; // b=2
    tg[3]  = 4'b0010; te[3]  = 5'b0_0110; // b=3
    tg[4]  = 4'b0110; te[4]  = 5'b0_0111; // b=4
    tg[5]  = 4'b0111; te[5]  = 5'b0_1000; // b=5
    tg[6]  = 4'b0101; te[6]  = 5'b0_1001; // b=6
    tg[7]  = 4'b0100; te[7]  = 5'b0_1010; // b=7
    tg[8]  = 4'b1100; te[8]  = 5'b0_1011; // b=8
    tg[9]  = 4'b1101; te[9]  = 5'b0_1100; // b=9
    tg[10] = 4'b1111; te[10] = 5'b1_0000; // b=10
    tg[11] = 4'b1110; te[11] = 5'b1_0000; // b=11
    tg[12] = 4'b1010; te[12] = 5'b1_0000; // b=12
    tg[13] = 4'b1000; te[13] = 5'b1_0000; // b=15
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset;
    rst = 1'b1; in_valid = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
  endtask

  // Present one digit and hold it until accepted (bounded wait).
  task automatic push(input int idx);
    int n = 0;
    in_valid = 1'b1; in_g = tg[idx];
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    if (in_ready) exp_q.push_back(te[idx]);
    else chk("push_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while (out_valid && n < 100) begin n++; @(negedge clk); end
    chk("drain_empty", out_valid, 0);
    chk("drain_queue", exp_q.size(), 0);
    tick();
    out_ready = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic       hold_prev = 1'b0;
  logic [4:0] data_prev = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (hold_prev && out_valid) chk("head_stable", {out_error, out_ex}, data_prev);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_output", {out_error, out_ex}, 32'hDEAD);
          else chk("sb_data", {out_error, out_ex}, exp_q.pop_front());
        end
        hold_prev = out_valid && !out_ready;
        data_prev = {out_error, out_ex};
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_g = '0; out_ready = 1'b0;
    tick();
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_ex", out_ex, 0);
    chk("rst_out_error", out_error, 0);
`ifdef GTOEX_ERR_CNT_EN
    chk("rst_err_cnt", err_cnt, 0);
`endif
    tick();

    // Latency: one cycle after acceptance into an empty FIFO
    out_ready = 1'b1;
    push(0);
    @(negedge clk);
    chk("latency_valid_0", out_valid, 1);
    tick();
    push(9);
    @(negedge clk);
    chk("latency_valid_9", out_valid, 1);
    tick();
    drain();

    // Every vector streamed back-to-back
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) push(i);
    drain();

    // Invalid digit bumps the error counter
    do_reset();
    out_ready = 1'b1;
    push(10);
    drain();
`ifdef GTOEX_ERR_CNT_EN
    chk("err_cnt_one", err_cnt, 1);
`endif

    // Fill to full, then a 5th digit must be refused
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(i + 1);
    @(negedge clk);
    chk("full_level", level, 4);
    chk("full_in_ready", in_ready, 0);
    tick();
    in_valid = 1'b1; in_g = tg[5];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_refuse", in_ready, 0);
      chk("full_head", {out_error, out_ex}, te[1]);
      tick();
    end
    in_valid = 1'b0;
    // Pop while full: the slot becomes visible only one cycle later
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_no_bypass", in_ready, 0);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("after_pop_in_ready", in_ready, 1);
    chk("after_pop_level", level, 3);
    tick();
    drain();

    // Simultaneous push and pop at level 2
    do_reset();
    out_ready = 1'b0;
    push(2);
    push(3);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_g = tg[k]; out_ready = 1'b1;
      @(negedge clk);
      chk("steady_level", level, 2);
      if (in_ready) exp_q.push_back(te[k]);
      else chk("steady_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("steady_level_end", level, 2);
    tick();
    drain();

    // Reset mid-stream with level 3 and a concurrent push/pop offered
    do_reset();
    out_ready = 1'b0;
    push(10);
    push(11);
    push(12);
    @(negedge clk);
    chk("pre_rst_level", level, 3);
    tick();
    rst = 1'b1; in_valid = 1'b1; in_g = tg[4]; out_ready = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_ex", {out_error, out_ex}, 0);
`ifdef GTOEX_ERR_CNT_EN
    chk("mid_rst_err_cnt", err_cnt, 0);
`endif
    tick();

`ifdef GTOEX_ERR_CNT_EN
    // Error counter saturation
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 300; k++) push(10 + (k % 4));
    drain();
    chk("err_cnt_sat", err_cnt, 255);
`endif

    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
